alu_arbiter: RTL and testbench

//  Shares one alu_ip instance between NUM_REQ requesters with round-robin arbitration.

---
 rtl/alu_arb_pkg.sv | 32 +++
 rtl/alu_arb_rsp_fifo.sv | 64 ++++++
 rtl/alu_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: opcode enum, request and response bundles.
// Also holds the operand and opcode widths.
package alu_arb_pkg;

    localparam int DATA_W   = 8;
    localparam int SEL_W    = 3;
    localparam int ID_W_MAX = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRA = 3'd6,
        OP_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e           sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [DATA_W-1:0]   c;
        logic                z;
    } rsp_t;

endpackage

// File: rtl/alu_arb_rsp_fifo.sv
// First-word fall-through response queue for the ALU arbiter.
// Ports: push/push_data in, pop in, out_valid/out_data out, count out (entries held).
module alu_arb_rsp_fifo
    import alu_arb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = rsp_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output logic                     out_valid,
    output T                         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // A full queue still takes a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != (PTR_W+1)'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU between NUM_REQ requesters.
// Ports: req_* (per-requester valid/ready + {sel,a,b}), alu_* (ALU operand/result),
// rsp_* (FWFT response with requester id), flush/flush_done (drain handshake).
// Optional macro ALU_ARB_STATS_EN adds stat_busy and stat_stall counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    output logic [SEL_W-1:0]             alu_sel,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    input  logic [DATA_W-1:0]            alu_c,
    input  logic                         alu_z,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DATA_W-1:0]            rsp_c,
    output logic                         rsp_z,
    input  logic                         flush,
    output logic                         flush_done
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]                  stat_busy,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    req_t              iss_q, iss_d;
    logic [ALU_LAT:0]  tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]   tag_id_q [ALU_LAT+1];
    logic [ID_W-1:0]   tag_id_d [ALU_LAT+1];

    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_found;
    logic              allow;
    logic              hs;
    logic [3:0]        inflight;
    logic [7:0]        used;
    logic              credit_ok;
    logic              drained;

    rsp_t              push_data;
    rsp_t              fifo_out;
    logic              fifo_valid;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              pop;
    logic              unused_id;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Tag stage 0 sits beside the issue register; the ALU_LAT stages after it
    // line up with alu_c. Every tag is a reserved FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight = inflight + 4'(tag_vld_q[i]);
        end
        used      = 8'(fifo_cnt) + 8'(inflight);
        credit_ok = (used < 8'(RSP_DEPTH));
        drained   = (inflight == '0) && !fifo_valid;
    end

    always_comb begin
        state_d    = state_q;
        allow      = 1'b0;
        flush_done = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                allow = credit_ok && !rst;
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    flush_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        hs        = allow && gnt_found;
        req_ready = hs ? (NUM_REQ'(1) << gnt_idx) : '0;
        rr_ptr_d  = rr_ptr_q;
        iss_d     = iss_q;
        if (hs) begin
            rr_ptr_d  = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
            iss_d.sel = alu_op_e'(req_sel[gnt_idx*SEL_W +: SEL_W]);
            iss_d.a   = req_a[gnt_idx*DATA_W +: DATA_W];
            iss_d.b   = req_b[gnt_idx*DATA_W +: DATA_W];
        end
        tag_vld_d    = {tag_vld_q[ALU_LAT-1:0], hs};
        tag_id_d[0]  = gnt_idx;
        for (int i = 1; i <= ALU_LAT; i++) begin
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            rr_ptr_q  <= '0;
            iss_q     <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            iss_q     <= iss_d;
            tag_vld_q <= tag_vld_d;
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    assign alu_sel = iss_q.sel;
    assign alu_a   = iss_q.a;
    assign alu_b   = iss_q.b;

    always_comb begin
        push_data    = '0;
        push_data.id = ID_W_MAX'(tag_id_q[ALU_LAT]);
        push_data.c  = alu_c;
        push_data.z  = alu_z;
    end

    alu_arb_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_vld_q[ALU_LAT]),
        .push_data (push_data),
        .pop       (pop),
        .out_valid (fifo_valid),
        .out_data  (fifo_out),
        .count     (fifo_cnt)
    );

    // Stale storage is masked so idle outputs read as zero.
    assign pop       = fifo_valid && rsp_ready;
    assign rsp_valid = fifo_valid;
    assign rsp_id    = fifo_valid ? ID_W'(fifo_out.id) : '0;
    assign rsp_c     = fifo_valid ? fifo_out.c : '0;
    assign rsp_z     = fifo_valid ? fifo_out.z : 1'b0;
    assign unused_id = ^fifo_out.id;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_busy_q, stat_busy_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_busy_d  = stat_busy_q;
        stat_stall_d = stat_stall_q;
        if (((inflight != '0) || fifo_valid) && (stat_busy_q != '1)) begin
            stat_busy_d = stat_busy_q + 32'd1;
        end
        if ((|req_valid) && !hs && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_busy_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_busy_q  <= stat_busy_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_busy  = stat_busy_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural one-cycle ALU.
// Grants and responses are checked by a monitor against a high-level model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N     = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*3-1:0]   req_sel;
    logic [N*8-1:0]   req_a;
    logic [N*8-1:0]   req_b;
    logic [2:0]       alu_sel;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [7:0]       alu_c = 8'd0;
    logic             alu_z = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [7:0]       rsp_c;
    logic             rsp_z;
    logic             flush;
    logic             flush_done;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]      stat_busy;
    logic [31:0]      stat_stall;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ   (N),
        .ALU_LAT   (LAT),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_c      (rsp_c),
        .rsp_z      (rsp_z),
        .flush      (flush),
        .flush_done (flush_done)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_busy  (stat_busy),
        .stat_stall (stat_stall)
`endif
    );

    function automatic logic [7:0] alu_f(input logic [2:0] s,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb2;
        sa  = a;
        sb2 = b;
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[2:0];
            3'd6:    return 8'(sa >>> b[2:0]);
            default: return (sa < sb2) ? 8'd1 : 8'd0;
        endcase
    endfunction

    // Stand-in for alu_ip with a one-cycle latency.
    always @(posedge clk) begin
        alu_c <= alu_f(alu_sel, alu_a, alu_b);
        alu_z <= (alu_f(alu_sel, alu_a, alu_b) == 8'd0);
    end

    typedef struct {
        int         id;
        logic [7:0] c;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   grant_q[$];
    int   ptr_m;
    int   checks   = 0;
    int   failures = 0;
    bit   arb_chk  = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Monitor: arbitration model, response scoreboard pop, issue push.
    always @(negedge clk) begin
        int         eg;
        int         g;
        logic [3:0] er;
        exp_t       e;
        if (rst) begin
            sb.delete();
            ptr_m = 0;
        end else begin
            if (arb_chk) begin
                eg = -1;
                if (sb.size() < DEPTH) begin
                    for (int i = 0; i < N; i++) begin
                        if (eg < 0 && req_valid[(ptr_m + i) % N]) begin
                            eg = (ptr_m + i) % N;
                        end
                    end
                end
                er = (eg < 0) ? 4'd0 : 4'(1 << eg);
                chk("arb_grant", req_ready, er);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_c", rsp_c, e.c);
                    chk("rsp_z", rsp_z, e.z);
                end
            end
            if (req_ready != '0) begin
                g = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (req_ready[i]) g = i;
                end
                chk("ready_onehot", $countones(req_ready), 1);
                chk("ready_has_valid", req_valid[g], 1);
                e.id = g;
                e.c  = alu_f(req_sel[g*3 +: 3], req_a[g*8 +: 8],
                             req_b[g*8 +: 8]);
                e.z  = (e.c == 8'd0);
                sb.push_back(e);
                grant_q.push_back(g);
                ptr_m = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_sel[i*3 +: 3] = 3'($urandom);
            req_a[i*8 +: 8]   = 8'($urandom);
            req_b[i*8 +: 8]   = 8'($urandom);
        end
    endtask

    task automatic set_op(input int r, input logic [2:0] s,
                          input logic [7:0] a, input logic [7:0] b);
        req_sel[r*3 +: 3] = s;
        req_a[r*8 +: 8]   = a;
        req_b[r*8 +: 8]   = b;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_drain", sb.size(), 0);
        step();
    endtask

    int g0;
    int ng0;
    int cnt;
    bit done;

    initial begin
        req_valid = '1;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        rand_ops();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_c", rsp_c, 0);
        chk("rst_rsp_z", rsp_z, 0);
        chk("rst_flush_done", flush_done, 0);
        step();
        rst       = 1'b0;
        req_valid = '0;
        step();

        // Single op on requester 2: 5 + (-3).
        set_op(2, OP_ADD, 8'd5, 8'hFD);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("single_alu_a", alu_a, 8'd5);
        chk("single_alu_b", alu_b, 8'hFD);
        chk("single_alu_sel", alu_sel, 3'd0);
        @(negedge clk);
        chk("single_rsp_early", rsp_valid, 0);
        @(negedge clk);
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 2);
        chk("single_rsp_c", rsp_c, 8'd2);
        chk("single_rsp_z", rsp_z, 0);
        wait_idle();

        // Zero flag: 7 - 7.
        set_op(1, OP_SUB, 8'd7, 8'd7);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        cnt = 0;
        while (!rsp_valid && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("zero_rsp_valid", rsp_valid, 1);
        chk("zero_rsp_c", rsp_c, 8'd0);
        chk("zero_rsp_z", rsp_z, 1);
        wait_idle();

        // Fairness: everyone valid, one grant per cycle in rotation.
        g0 = grant_q.size();
        for (int k = 0; k < 16; k++) begin
            rand_ops();
            req_valid = '1;
            step();
        end
        req_valid = '0;
        chk("rr_count", grant_q.size() - g0, 16);
        for (int i = g0 + 1; i < grant_q.size(); i++) begin
            chk("rr_order", grant_q[i], (grant_q[i-1] + 1) % N);
        end
        wait_idle();

        // Backpressure: credits limit grants to the FIFO depth.
        rsp_ready = 1'b0;
        g0 = grant_q.size();
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            step();
        end
        @(negedge clk);
        chk("bp_grants", grant_q.size() - g0, 4);
        chk("bp_ready_low", req_ready, 0);
        step();
        rsp_ready = 1'b1;
        repeat (8) step();
        chk("bp_resume", (grant_q.size() - g0) > 4, 1);
        req_valid = '0;
        wait_idle();

        // Random traffic with random consumer stalls.
        for (int k = 0; k < 300; k++) begin
            rand_ops();
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        // Flush with two ops in flight.
        arb_chk = 1'b0;
        g0 = grant_q.size();
        rand_ops();
        req_valid = 4'b0011;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        ng0  = grant_q.size();
        cnt  = 0;
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) cnt++;
            if (flush_done) begin
                done = 1'b1;
                break;
            end
        end
        chk("flush_pre_grants", ng0 - g0, 2);
        chk("flush_no_grants", grant_q.size() - ng0, 0);
        chk("flush_rsps", cnt, 2);
        chk("flush_done_seen", done, 1);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 0);
        chk("flush_resume", req_ready != '0, 1);
        step();
        req_valid = '0;
        wait_idle();
        arb_chk = 1'b1;

        // Reset with three ops outstanding.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        step();
        req_valid = '1;
        rst = 1'b1;
        #1;
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_req_ready", req_ready, 0);
        chk("mrst_alu_a", alu_a, 0);
        chk("mrst_alu_sel", alu_sel, 0);
        chk("mrst_rsp_c", rsp_c, 0);
        step();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("mrst_no_stale", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
